serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing `a - b - borrow_in`, one bit per clock, LSB first.
- Built around the team's existing one-bit full-subtractor cell, with a registered borrow fed back between bit slices.
- Sits downstream of the operand source and upstream of result consumers.
- Trades latency for area against the ripple-chained subtractor built from the same cell.

---
 rtl/serial_subtractor_pkg.sv | 5 +
 rtl/serial_subtractor_fullsub.sv | 11 +
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/serial_subtractor_fullsub.sv
// One-bit full-subtractor cell: D = a - b - prevb (mod 2), B = borrow out.
module fullsub (
  input  logic a,
  input  logic b,
  input  logic prevb,
  output logic D,
  output logic B
);
  assign D = a ^ b ^ prevb;
  assign B = (~a & b) | (~a & prevb) | (b & prevb);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - borrow_in), LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to build the signed-overflow flag.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);
  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q, diff_q;
  logic               brw_q, bout_q;
  logic               cell_d, cell_b, last_bit;
  logic [WIDTH-1:0]   res_d;

  fullsub u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .prevb(brw_q),
    .D    (cell_d),
    .B    (cell_b)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign res_d    = {cell_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      brw_q  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          brw_q <= borrow_in;
          cnt_q <= '0;
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          brw_q <= cell_b;
          if (last_bit) begin
            // Outputs only move on the edge into DONE, never bit-by-bit.
            diff_q <= res_d;
            bout_q <= cell_b;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic sa_q, sb_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      sa_q <= a[WIDTH-1];
      sb_q <= b[WIDTH-1];
    end else if (state_q == SHIFT && last_bit) begin
      ovf_q <= (sa_q != sb_q) && (cell_d != sa_q);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + random checks of serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         borrow_in = 1'b0;
  logic         busy, done, borrow_out, ovf;
  logic [W-1:0] diff;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .borrow_in(borrow_in), .busy(busy), .done(done), .diff(diff),
    .borrow_out(borrow_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W-1:0] m_diff(input int ua, input int ub, input int bi);
    int r;
    r = ua - ub - bi;
    return W'(r);
  endfunction

  function automatic logic m_bout(input int ua, input int ub, input int bi);
    return (ua < ub + bi);
  endfunction

  function automatic logic m_ovf(input int ua, input int ub, input int bi);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    int sa, sb, r;
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    r  = sa - sb - bi;
    return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; optionally pulses start with other operands at cycles 3 and W+1.
  task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic bi, input bit glitch);
    int c, done_at, ndone;
    logic seen_bad;
    a = oa; b = ob; borrow_in = bi; start = 1'b1;
    step();
    start = 1'b0;
    c = 1; done_at = -1; ndone = 0; seen_bad = 1'b0;
    while (c <= 2 * W + 8) begin
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
        chk({tag, ".diff"}, 32'(diff), 32'(m_diff(oa, ob, bi)));
        chk({tag, ".bout"}, 32'(borrow_out), 32'(m_bout(oa, ob, bi)));
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf(oa, ob, bi)));
        chk({tag, ".busy_done"}, 32'(busy), 32'd1);
      end else if (c <= W && !busy) begin
        seen_bad = 1'b1;
      end
      if (glitch && (c == 3 || c == W + 1)) begin
        start = 1'b1; a = ~oa; b = oa; borrow_in = ~bi;
      end else begin
        start = 1'b0;
      end
      if (c == W + 3) break;
      step();
      c++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 32'(done_at), 32'(W + 1));
    chk({tag, ".ndone"}, 32'(ndone), 32'd1);
    chk({tag, ".busy_shift"}, 32'(seen_bad), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".hold"}, 32'(diff), 32'(m_diff(oa, ob, bi)));
  endtask

  initial begin
    #2;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.diff", 32'(diff), 32'd0);
    chk("rst.bout", 32'(borrow_out), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    run_op("d05_03", 8'h05, 8'h03, 1'b0, 1'b0);
    run_op("d03_05", 8'h03, 8'h05, 1'b0, 1'b0);
    run_op("d00_00b", 8'h00, 8'h00, 1'b1, 1'b0);
    run_op("d80_01", 8'h80, 8'h01, 1'b0, 1'b0);
    run_op("dFF_FFb", 8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op("glitch", 8'h5A, 8'h3C, 1'b1, 1'b1);

    // Reset in the middle of an operation.
    a = 8'hC3; b = 8'h11; borrow_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.done", 32'(done), 32'd0);
    chk("mrst.diff", 32'(diff), 32'd0);
    chk("mrst.bout", 32'(borrow_out), 32'd0);
    chk("mrst.ovf", 32'(ovf), 32'd0);
    step();
    rst_n = 1'b1;
    begin
      int nd;
      nd = 0;
      for (int i = 0; i < W + 4; i++) begin
        if (done || busy) nd++;
        step();
      end
      chk("mrst.no_done", 32'(nd), 32'd0);
    end
    run_op("dA0_0F", 8'hA0, 8'h0F, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra, rb;
      logic         rbi;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rbi = 1'($urandom);
      run_op($sformatf("rnd%0d", i), ra, rb, rbi, 1'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
